// File: rtl/noc_out_arbiter_pkg.sv
// Shared definitions for the output-port arbiter: flit-type codes,
// source port indices and the lock FSM state type.
package noc_out_arbiter_pkg;

  // Flit type codes, carried in the top FLIT_TYPE_W bits of every flit
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  localparam int         FLIT_TYPE_W = 2;

  // Source port indices
  localparam logic [1:0] PORT_E = 2'd0;
  localparam logic [1:0] PORT_S = 2'd1;
  localparam logic [1:0] PORT_W = 2'd2;
  localparam logic [1:0] PORT_L = 2'd3;
  localparam int         NUM_PORTS = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/noc_out_arbiter_rr_arb4.sv
// Combinational 4-way round-robin picker: the first requester found
// scanning upward from ptr (wrapping) wins.
module rr_arb4
  import noc_out_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt_onehot,
  output logic [1:0] gnt_idx
);

  logic [1:0] idx;
  logic       found;

  // Rotating priority scan starting at ptr
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Wormhole-aware output-port arbiter: picks one of four source FIFOs,
// keeps a multi-flit packet on the port from head to tail, and forwards
// one flit per cycle through a registered hold stage that honours the
// downstream full flag.
module noc_out_arbiter
  import noc_out_arbiter_pkg::*;
#(
  parameter int DATASIZE = 40
) (
  input  logic                fifo_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                E_valid_in,
  input  logic                S_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,
  output logic                E_ready_out,
  output logic                S_ready_out,
  output logic                W_ready_out,
  output logic                L_ready_out,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_full,
  output logic                locked,
  output logic                proto_err
);

  lock_state_t         state, state_d;
  logic [1:0]          lock_src, lock_src_d;
  logic [1:0]          rr_ptr, rr_ptr_d;
  logic                proto_err_d;
  logic                hold_valid;
  logic                load_ok;
  logic                pop;
  logic [3:0]          req;
  logic [3:0]          gnt_onehot;
  logic [1:0]          gnt_idx;
  logic [1:0]          cand;
  logic                cand_valid;
  logic [DATASIZE-1:0] pop_data;
  logic [1:0]          pop_type;

  assign req = {L_valid_in, W_valid_in, S_valid_in, E_valid_in};

  rr_arb4 u_rr_arb4 (
    .req        (req),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  // While a packet owns the port only its source may be popped, even if
  // it runs dry; otherwise the round-robin winner is the candidate.
  assign locked     = (state == ST_LOCKED);
  assign cand       = locked ? lock_src : gnt_idx;
  assign cand_valid = locked ? req[lock_src] : |gnt_onehot;

  assign out_valid = hold_valid & ~out_full;
  assign load_ok   = ~hold_valid | ~out_full;
  assign pop       = load_ok & cand_valid;

  // Reset gates the pop requests combinationally so sources never pop
  // while the arbiter is held in reset.
  assign E_ready_out = pop & (cand == PORT_E) & ~rst;
  assign S_ready_out = pop & (cand == PORT_S) & ~rst;
  assign W_ready_out = pop & (cand == PORT_W) & ~rst;
  assign L_ready_out = pop & (cand == PORT_L) & ~rst;

  // Select the flit being popped from the granted source
  always_comb begin
    pop_data = '0;
    case (cand)
      PORT_E:  pop_data = E_data_in;
      PORT_S:  pop_data = S_data_in;
      PORT_W:  pop_data = W_data_in;
      default: pop_data = L_data_in;
    endcase
  end

  assign pop_type = pop_data[DATASIZE-1 -: FLIT_TYPE_W];

  // Lock FSM next state, pointer update and protocol checking
  always_comb begin
    state_d     = state;
    lock_src_d  = lock_src;
    rr_ptr_d    = rr_ptr;
    proto_err_d = 1'b0;
    if (pop) begin
      case (state)
        ST_IDLE: begin
          if (pop_type == FLIT_HEAD) begin
            state_d    = ST_LOCKED;
            lock_src_d = cand;
          end else begin
            // Stray body/tail flits are treated as singles
            rr_ptr_d    = cand + 2'd1;
            proto_err_d = (pop_type == FLIT_BODY) | (pop_type == FLIT_TAIL);
          end
        end
        ST_LOCKED: begin
          if (pop_type == FLIT_TAIL) begin
            state_d  = ST_IDLE;
            rr_ptr_d = cand + 2'd1;
          end else begin
            // A new head/single inside a packet is forwarded; lock is kept
            proto_err_d = (pop_type == FLIT_HEAD) | (pop_type == FLIT_SINGLE);
          end
        end
      endcase
    end
  end

  // Lock FSM and arbitration state registers
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lock_src  <= PORT_E;
      rr_ptr    <= PORT_E;
      proto_err <= 1'b0;
    end else begin
      state     <= state_d;
      lock_src  <= lock_src_d;
      rr_ptr    <= rr_ptr_d;
      proto_err <= proto_err_d;
    end
  end

  // Hold register: load on pop (replacing a draining flit with no bubble),
  // otherwise empty out once the held flit has been taken downstream.
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      out_data   <= '0;
    end else if (pop) begin
      hold_valid <= 1'b1;
      out_data   <= pop_data;
    end else if (out_valid) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed, table-driven bench for noc_out_arbiter. Each table row gives the
// source inputs for one cycle and the outputs expected just before the next
// clock edge; hand-written sequences cover reset behaviour.
module tb_noc_out_arbiter;

  localparam int DW = 40;
  localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

  logic          fifo_clk;
  logic          rst;
  logic [3:0]    vin;
  logic [DW-1:0] din [4];
  logic          out_full;
  logic          E_ready_out, S_ready_out, W_ready_out, L_ready_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          locked;
  logic          proto_err;

  int checks   = 0;
  int failures = 0;

  noc_out_arbiter #(.DATASIZE(DW)) dut (
    .fifo_clk    (fifo_clk),
    .rst         (rst),
    .E_data_in   (din[0]),
    .S_data_in   (din[1]),
    .W_data_in   (din[2]),
    .L_data_in   (din[3]),
    .E_valid_in  (vin[0]),
    .S_valid_in  (vin[1]),
    .W_valid_in  (vin[2]),
    .L_valid_in  (vin[3]),
    .E_ready_out (E_ready_out),
    .S_ready_out (S_ready_out),
    .W_ready_out (W_ready_out),
    .L_ready_out (L_ready_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_full    (out_full),
    .locked      (locked),
    .proto_err   (proto_err)
  );

  initial begin
    fifo_clk = 1'b0;
    forever #5 fifo_clk = ~fifo_clk;
  end

  typedef struct {
    logic [3:0] vld;   // {L,W,S,E}
    logic [7:0] typ;   // {tL,tW,tS,tE}
    logic       full;
    logic [3:0] rdy;
    logic       oval;
    logic       chk_d;
    logic [1:0] dtyp;
    int         drow;
    int         dsrc;
    logic       lock;
    logic       perr;
  } vec_t;

  localparam int NROWS = 26;
  vec_t tbl [NROWS];

  // Flit tagged with its type, the row it was offered in and its source
  function automatic logic [DW-1:0] mk(input logic [1:0] typ, input int row, input int src);
    return {typ, 22'd0, 8'(row), 8'(src)};
  endfunction

  function automatic vec_t v(input logic [3:0] vld,
                             input logic [1:0] tl, input logic [1:0] tw,
                             input logic [1:0] ts, input logic [1:0] te,
                             input logic full, input logic [3:0] rdy,
                             input logic oval, input logic chk_d,
                             input logic [1:0] dtyp, input int drow, input int dsrc,
                             input logic lock, input logic perr);
    vec_t r;
    r.vld = vld; r.typ = {tl, tw, ts, te}; r.full = full; r.rdy = rdy;
    r.oval = oval; r.chk_d = chk_d; r.dtyp = dtyp; r.drow = drow; r.dsrc = dsrc;
    r.lock = lock; r.perr = perr;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rdy_vec();
    return {L_ready_out, W_ready_out, S_ready_out, E_ready_out};
  endfunction

  initial begin
    // Two singles from E and S; E first, then S
    tbl[0]  = v(4'b0011, S,S,S,S, 0, 4'b0001, 0,0, S, 0,0, 0,0);
    tbl[1]  = v(4'b0010, S,S,S,S, 0, 4'b0010, 1,1, S, 0,0, 0,0);
    tbl[2]  = v(4'b0000, S,S,S,S, 0, 4'b0000, 1,1, S, 1,1, 0,0);
    // Pointer now at W: W head wins over S and L
    tbl[3]  = v(4'b1110, S,H,S,S, 0, 4'b0100, 0,0, S, 0,0, 0,0);
    tbl[4]  = v(4'b1110, S,B,S,S, 0, 4'b0100, 1,1, H, 3,2, 1,0);
    // Three cycles of backpressure mid-packet
    tbl[5]  = v(4'b1110, S,B,S,S, 1, 4'b0000, 0,1, B, 4,2, 1,0);
    tbl[6]  = v(4'b1110, S,B,S,S, 1, 4'b0000, 0,1, B, 4,2, 1,0);
    tbl[7]  = v(4'b1110, S,B,S,S, 1, 4'b0000, 0,1, B, 4,2, 1,0);
    tbl[8]  = v(4'b1110, S,B,S,S, 0, 4'b0100, 1,1, B, 4,2, 1,0);
    // W runs dry while locked: nobody else is granted
    tbl[9]  = v(4'b1010, S,B,S,S, 0, 4'b0000, 1,1, B, 8,2, 1,0);
    tbl[10] = v(4'b1110, S,T,S,S, 0, 4'b0100, 0,0, S, 0,0, 1,0);
    // After W tail, pointer at L
    tbl[11] = v(4'b1010, S,S,S,S, 0, 4'b1000, 1,1, T,10,2, 0,0);
    // Fairness: all four continuously valid
    tbl[12] = v(4'b1111, S,S,S,S, 0, 4'b0001, 1,1, S,11,3, 0,0);
    tbl[13] = v(4'b1111, S,S,S,S, 0, 4'b0010, 1,1, S,12,0, 0,0);
    tbl[14] = v(4'b1111, S,S,S,S, 0, 4'b0100, 1,1, S,13,1, 0,0);
    tbl[15] = v(4'b1111, S,S,S,S, 0, 4'b1000, 1,1, S,14,2, 0,0);
    tbl[16] = v(4'b1111, S,S,S,S, 0, 4'b0001, 1,1, S,15,3, 0,0);
    // Body flit at idle E
    tbl[17] = v(4'b0001, S,S,S,B, 0, 4'b0001, 1,1, S,16,0, 0,0);
    tbl[18] = v(4'b0000, S,S,S,S, 0, 4'b0000, 1,1, B,17,0, 0,1);
    // Head inside a locked S packet
    tbl[19] = v(4'b0010, S,S,H,S, 0, 4'b0010, 0,0, S, 0,0, 0,0);
    tbl[20] = v(4'b0011, S,S,H,S, 0, 4'b0010, 1,1, H,19,1, 1,0);
    tbl[21] = v(4'b0011, S,S,T,S, 0, 4'b0010, 1,1, H,20,1, 1,1);
    tbl[22] = v(4'b0001, S,S,S,S, 0, 4'b0001, 1,1, T,21,1, 0,0);
    // Full with an idle arbiter, then drain
    tbl[23] = v(4'b0000, S,S,S,S, 1, 4'b0000, 0,1, S,22,0, 0,0);
    tbl[24] = v(4'b0000, S,S,S,S, 0, 4'b0000, 1,1, S,22,0, 0,0);
    tbl[25] = v(4'b0000, S,S,S,S, 0, 4'b0000, 0,0, S, 0,0, 0,0);

    // Reset with every source valid: nothing may be popped
    rst = 1'b1;
    out_full = 1'b0;
    vin = 4'b1111;
    for (int i = 0; i < 4; i++) din[i] = mk(S, 99, i);
    #3;
    check("reset ready", 64'(rdy_vec()), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset locked", 64'(locked), 64'd0);
    check("reset proto_err", 64'(proto_err), 64'd0);
    @(posedge fifo_clk); #1;
    rst = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      vin = tbl[r].vld;
      out_full = tbl[r].full;
      for (int i = 0; i < 4; i++) din[i] = mk(tbl[r].typ[2*i +: 2], r, i);
      #7;
      check($sformatf("row%0d ready", r), 64'(rdy_vec()), 64'(tbl[r].rdy));
      check($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tbl[r].oval));
      check($sformatf("row%0d locked", r), 64'(locked), 64'(tbl[r].lock));
      check($sformatf("row%0d proto_err", r), 64'(proto_err), 64'(tbl[r].perr));
      if (tbl[r].chk_d)
        check($sformatf("row%0d out_data", r), 64'(out_data),
              64'(mk(tbl[r].dtyp, tbl[r].drow, tbl[r].dsrc)));
      @(posedge fifo_clk); #1;
    end

    // Mid-packet reset: S head and body, then reset while locked
    vin = 4'b0010; din[1] = mk(H, 30, 1); #7;
    check("mid S head ready", 64'(rdy_vec()), 64'b0010);
    @(posedge fifo_clk); #1;
    din[1] = mk(B, 31, 1); #7;
    check("mid S body ready", 64'(rdy_vec()), 64'b0010);
    check("mid locked", 64'(locked), 64'd1);
    @(posedge fifo_clk); #1;
    vin = 4'b0011; din[0] = mk(S, 32, 0); din[1] = mk(B, 32, 1);
    #1 rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst out_data", 64'(out_data), 64'd0);
    check("async rst locked", 64'(locked), 64'd0);
    check("async rst ready", 64'(rdy_vec()), 64'd0);
    @(posedge fifo_clk); #1;
    rst = 1'b0;
    vin = 4'b0011; din[0] = mk(S, 40, 0); din[1] = mk(S, 40, 1); #7;
    check("post rst ready E first", 64'(rdy_vec()), 64'b0001);
    check("post rst out_valid", 64'(out_valid), 64'd0);
    @(posedge fifo_clk); #1;
    vin = 4'b0010; din[1] = mk(S, 41, 1); #7;
    check("post rst ready S", 64'(rdy_vec()), 64'b0010);
    check("post rst out_data", 64'(out_data), 64'(mk(S, 40, 0)));
    check("post rst out_valid E", 64'(out_valid), 64'd1);
    @(posedge fifo_clk); #1;
    vin = 4'b0000; #7;
    check("post rst out_data S", 64'(out_data), 64'(mk(S, 41, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
